// File: rtl/vslc_led_shifter.sv
// rtl/vslc_led_shifter.sv - serialises the core LED byte onto a 74HC595-style SER/SRCLK/RCLK chain
module vslc_led_shifter #(
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_in,
  input  logic       strobe,
  output logic       ser,
  output logic       srclk,
  output logic       rclk,
  output logic       busy,
  output logic [7:0] shown
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic [7:0] shown_q, shown_d;
  logic       ser_q, ser_d;
  logic       srclk_q, srclk_d;
  logic       rclk_q, rclk_d;
  logic       busy_q, busy_d;
  logic       div_done;
  logic [2:0] bit_idx;

  assign ser   = ser_q;
  assign srclk = srclk_q;
  assign rclk  = rclk_q;
  assign busy  = busy_q;
  assign shown = shown_q;

  // Next-state, buffering and registered-output decode for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    shown_d     = shown_q;
    ser_d       = ser_q;
    srclk_d     = 1'b0;
    rclk_d      = 1'b0;
    busy_d      = 1'b0;
    bit_idx     = 3'd0;
    div_done    = (div_q == DIV_LAST);

    // Strobes outside IDLE park in the pending slot; the newest one wins.
    if (strobe && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_data_d = led_in;
    end

    case (state_q)
      IDLE: begin
        if (strobe || pend_q) begin
          // A fresh strobe beats an older pending value and discards it.
          data_d  = strobe ? led_in : pend_data_q;
          pend_d  = 1'b0;
          div_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_done) begin
          div_d   = 8'd0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LATCH: begin
        if (div_done) begin
          div_d   = 8'd0;
          shown_d = data_q;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:     ser_d = 1'b0;
      SHIFT_LO: begin
        // ser only moves on entry to SHIFT_LO, keeping it stable around each SRCLK rise.
        if (state_q != SHIFT_LO) begin
          bit_idx = MSB_FIRST ? (3'd7 - bit_d) : bit_d;
          ser_d   = data_d[bit_idx];
        end
      end
      SHIFT_HI: srclk_d = 1'b1;
      LATCH: begin
        rclk_d = 1'b1;
        ser_d  = 1'b0;
      end
      default: ser_d = 1'b0;
    endcase
  end

  // State, counters, buffers and registered outputs; reset drops everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      data_q      <= 8'h00;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      shown_q     <= 8'h00;
      ser_q       <= 1'b0;
      srclk_q     <= 1'b0;
      rclk_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      shown_q     <= shown_d;
      ser_q       <= ser_d;
      srclk_q     <= srclk_d;
      rclk_q      <= rclk_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_vslc_led_shifter.sv
// tb/tb_vslc_led_shifter.sv - directed self-checking bench for vslc_led_shifter
module tb_vslc_led_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_a = 8'h00, led_b = 8'h00;
  logic       strobe_a = 1'b0, strobe_b = 1'b0;
  logic       ser_a, srclk_a, rclk_a, busy_a;
  logic       ser_b, srclk_b, rclk_b, busy_b;
  logic [7:0] shown_a, shown_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vslc_led_shifter #(.CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .led_in(led_a), .strobe(strobe_a),
    .ser(ser_a), .srclk(srclk_a), .rclk(rclk_a), .busy(busy_a), .shown(shown_a)
  );

  vslc_led_shifter #(.CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .led_in(led_b), .strobe(strobe_b),
    .ser(ser_b), .srclk(srclk_b), .rclk(rclk_b), .busy(busy_b), .shown(shown_b)
  );

  // Observers: bits are gathered in arrival order, first bit ends up in bit 7.
  logic [7:0] bits_a = 8'h00, bits_b = 8'h00;
  logic       srclk_a_q = 1'b0, rclk_a_q = 1'b0, busy_a_q = 1'b0;
  logic       srclk_b_q = 1'b0, rclk_b_q = 1'b0, busy_b_q = 1'b0;
  int srclk_rises_a = 0, rclk_pulses_a = 0, rclk_cycles_a = 0;
  int srclk_rises_b = 0, rclk_pulses_b = 0;
  int busy_cnt_a = 0, gap_cnt_a = 0, busy_cnt_b = 0;
  logic [7:0] xfer_a [0:63];
  int         busy_log_a [0:63];
  int         gap_log_a [0:63];
  logic [7:0] xfer_b [0:63];
  int         busy_log_b [0:63];
  int xfer_n_a = 0, busy_n_a = 0, gap_n_a = 0, xfer_n_b = 0, busy_n_b = 0;

  always @(negedge clk) begin
    if (srclk_a && !srclk_a_q) begin
      bits_a = {bits_a[6:0], ser_a};
      srclk_rises_a++;
    end
    if (rclk_a) rclk_cycles_a++;
    if (rclk_a && !rclk_a_q) begin
      rclk_pulses_a++;
      if (xfer_n_a < 64) xfer_a[xfer_n_a] = bits_a;
      xfer_n_a++;
    end
    if (busy_a && !busy_a_q) begin
      if (gap_n_a < 64) gap_log_a[gap_n_a] = gap_cnt_a;
      gap_n_a++;
    end
    if (!busy_a && busy_a_q) begin
      if (busy_n_a < 64) busy_log_a[busy_n_a] = busy_cnt_a;
      busy_n_a++;
    end
    if (busy_a) begin
      busy_cnt_a++;
      gap_cnt_a = 0;
    end else begin
      busy_cnt_a = 0;
      gap_cnt_a++;
    end
    srclk_a_q = srclk_a;
    rclk_a_q  = rclk_a;
    busy_a_q  = busy_a;
  end

  always @(negedge clk) begin
    if (srclk_b && !srclk_b_q) begin
      bits_b = {bits_b[6:0], ser_b};
      srclk_rises_b++;
    end
    if (rclk_b && !rclk_b_q) begin
      rclk_pulses_b++;
      if (xfer_n_b < 64) xfer_b[xfer_n_b] = bits_b;
      xfer_n_b++;
    end
    if (!busy_b && busy_b_q) begin
      if (busy_n_b < 64) busy_log_b[busy_n_b] = busy_cnt_b;
      busy_n_b++;
    end
    if (busy_b) busy_cnt_b++;
    else        busy_cnt_b = 0;
    srclk_b_q = srclk_b;
    rclk_b_q  = rclk_b;
    busy_b_q  = busy_b;
  end

  task automatic pulse_a(input logic [7:0] v);
    strobe_a = 1'b1;
    led_a    = v;
    @(negedge clk);
    strobe_a = 1'b0;
  endtask

  task automatic test_reset;
    int rp0;
    repeat (2) @(negedge clk);
    n_checks++; if (ser_a !== 1'b0)    begin n_fail++; $display("FAIL reset_ser got %b want 0", ser_a); end
    n_checks++; if (srclk_a !== 1'b0)  begin n_fail++; $display("FAIL reset_srclk got %b want 0", srclk_a); end
    n_checks++; if (rclk_a !== 1'b0)   begin n_fail++; $display("FAIL reset_rclk got %b want 0", rclk_a); end
    n_checks++; if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_checks++; if (shown_a !== 8'h00) begin n_fail++; $display("FAIL reset_shown got %h want 00", shown_a); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Reset landing in the middle of a transfer.
    rp0 = rclk_pulses_a;
    pulse_a(8'hFF);
    repeat (9) @(negedge clk);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b want 1", busy_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ser_a, srclk_a, rclk_a, busy_a} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_outputs got %b want 0000", {ser_a, srclk_a, rclk_a, busy_a});
    end
    n_checks++; if (shown_a !== 8'h00) begin n_fail++; $display("FAIL midreset_shown got %h want 00", shown_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (rclk_pulses_a != rp0) begin
      n_fail++; $display("FAIL midreset_no_rclk got %0d pulses want 0", rclk_pulses_a - rp0);
    end
    n_checks++; if (shown_a !== 8'h00) begin n_fail++; $display("FAIL midreset_shown_after got %h want 00", shown_a); end
  endtask

  task automatic test_single_byte;
    int x0 = xfer_n_a, b0 = busy_n_a, s0 = srclk_rises_a, rc0 = rclk_cycles_a;
    pulse_a(8'hA5);
    repeat (50) @(negedge clk);
    n_checks++; if (xfer_n_a - x0 != 1) begin n_fail++; $display("FAIL single_xfer_count got %0d want 1", xfer_n_a - x0); end
    n_checks++; if (xfer_a[x0] !== 8'hA5) begin n_fail++; $display("FAIL single_ser_bits got %h want a5", xfer_a[x0]); end
    n_checks++; if (srclk_rises_a - s0 != 8) begin n_fail++; $display("FAIL single_srclk got %0d want 8", srclk_rises_a - s0); end
    n_checks++; if (rclk_cycles_a - rc0 != 2) begin n_fail++; $display("FAIL single_rclk_len got %0d want 2", rclk_cycles_a - rc0); end
    n_checks++; if (busy_log_a[b0] != 34) begin n_fail++; $display("FAIL single_busy_len got %0d want 34", busy_log_a[b0]); end
    n_checks++; if (shown_a !== 8'hA5) begin n_fail++; $display("FAIL single_shown got %h want a5", shown_a); end
  endtask

  task automatic test_lsb_first;
    int x0 = xfer_n_b, b0 = busy_n_b, s0 = srclk_rises_b;
    strobe_b = 1'b1;
    led_b    = 8'h01;
    @(negedge clk);
    strobe_b = 1'b0;
    repeat (30) @(negedge clk);
    // Arrival order 1,0,0,0,0,0,0,0 collects as 8'h80.
    n_checks++; if (xfer_b[x0] !== 8'h80) begin n_fail++; $display("FAIL lsb_ser_bits got %h want 80", xfer_b[x0]); end
    n_checks++; if (xfer_n_b - x0 != 1) begin n_fail++; $display("FAIL lsb_xfer_count got %0d want 1", xfer_n_b - x0); end
    n_checks++; if (srclk_rises_b - s0 != 8) begin n_fail++; $display("FAIL lsb_srclk got %0d want 8", srclk_rises_b - s0); end
    n_checks++; if (busy_log_b[b0] != 17) begin n_fail++; $display("FAIL lsb_busy_len got %0d want 17", busy_log_b[b0]); end
    n_checks++; if (shown_b !== 8'h01) begin n_fail++; $display("FAIL lsb_shown got %h want 01", shown_b); end
  endtask

  task automatic test_latest_wins;
    int x0 = xfer_n_a, g0 = gap_n_a;
    for (int c = 0; c < 100; c++) begin
      strobe_a = (c == 0) || (c == 5) || (c == 9);
      led_a    = (c == 0) ? 8'h11 : (c == 5) ? 8'h22 : 8'h33;
      @(negedge clk);
    end
    strobe_a = 1'b0;
    n_checks++; if (xfer_n_a - x0 != 2) begin n_fail++; $display("FAIL latest_xfer_count got %0d want 2", xfer_n_a - x0); end
    n_checks++; if (xfer_a[x0] !== 8'h11) begin n_fail++; $display("FAIL latest_first got %h want 11", xfer_a[x0]); end
    n_checks++; if (xfer_a[x0+1] !== 8'h33) begin n_fail++; $display("FAIL latest_second got %h want 33", xfer_a[x0+1]); end
    n_checks++; if (gap_log_a[g0+1] != 1) begin n_fail++; $display("FAIL latest_idle_gap got %0d want 1", gap_log_a[g0+1]); end
    n_checks++; if (shown_a !== 8'h33) begin n_fail++; $display("FAIL latest_shown got %h want 33", shown_a); end
  endtask

  task automatic test_idle_gap_strobe;
    int x0 = xfer_n_a;
    bit seen_idle = 1'b0;
    pulse_a(8'h11);
    repeat (5) @(negedge clk);
    pulse_a(8'h44);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_a) begin
        seen_idle = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen_idle) begin n_fail++; $display("FAIL gap_wait_idle got timeout want busy low"); end
    pulse_a(8'h55);
    repeat (50) @(negedge clk);
    n_checks++; if (xfer_n_a - x0 != 2) begin n_fail++; $display("FAIL gap_xfer_count got %0d want 2", xfer_n_a - x0); end
    n_checks++; if (xfer_a[x0+1] !== 8'h55) begin n_fail++; $display("FAIL gap_second got %h want 55", xfer_a[x0+1]); end
    n_checks++; if (shown_a !== 8'h55) begin n_fail++; $display("FAIL gap_shown got %h want 55", shown_a); end
  endtask

  task automatic test_back_to_back_repeat;
    int x0 = xfer_n_a, b0 = busy_n_a, s0 = srclk_rises_a, r0 = rclk_pulses_a;
    for (int c = 0; c < 100; c++) begin
      strobe_a = (c == 0) || (c == 40);
      led_a    = 8'h0F;
      @(negedge clk);
    end
    strobe_a = 1'b0;
    n_checks++; if (xfer_n_a - x0 != 2) begin n_fail++; $display("FAIL repeat_xfer_count got %0d want 2", xfer_n_a - x0); end
    n_checks++; if (xfer_a[x0] !== 8'h0F || xfer_a[x0+1] !== 8'h0F) begin
      n_fail++; $display("FAIL repeat_bits got %h %h want 0f 0f", xfer_a[x0], xfer_a[x0+1]);
    end
    n_checks++; if (busy_log_a[b0] != 34 || busy_log_a[b0+1] != 34) begin
      n_fail++; $display("FAIL repeat_busy_len got %0d %0d want 34 34", busy_log_a[b0], busy_log_a[b0+1]);
    end
    n_checks++; if (srclk_rises_a - s0 != 16) begin n_fail++; $display("FAIL repeat_srclk got %0d want 16", srclk_rises_a - s0); end
    n_checks++; if (rclk_pulses_a - r0 != 2) begin n_fail++; $display("FAIL repeat_rclk got %0d want 2", rclk_pulses_a - r0); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_lsb_first;
    test_latest_wins;
    repeat (5) @(negedge clk);
    test_idle_gap_strobe;
    repeat (5) @(negedge clk);
    test_back_to_back_repeat;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vslc_led_shifter.md
Name: vslc_led_shifter

Overview:
- Output stage directly downstream of the vslc core. Consumes the core's 8-bit `ledout` bus and its `addr_strobe` pulse.
- On each strobe it serialises the LED byte onto an external 74HC595-style shift-register chain (SER/SRCLK/RCLK) at a divided clock rate.
- Lets the tile drive eight status LEDs over three pins without stalling the core. Strobes arriving mid-transfer are buffered, and the latest value wins.

Parameters:
- CLK_DIV, 4, clk cycles per SRCLK half-period and per RCLK pulse; legal range 1..255.
- MSB_FIRST, 1, 1 = bit 7 shifted first; 0 = bit 0 shifted first.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- led_in  input  8  LED byte from core (`ledout`)
- strobe  input  1  single-cycle update request from core (`addr_strobe`); level sampled every clk edge
- ser  output  1  serial data to '595 SER
- srclk  output  1  shift clock to '595 SRCLK
- rclk  output  1  storage/latch clock to '595 RCLK
- busy  output  1  high while a transfer is in progress
- shown  output  8  value most recently latched into the '595 chain

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ser=0, srclk=0, rclk=0, busy=0, shown=8'h00.
  - Pending flag and pending register cleared; divider and bit counter cleared.
  - Takes effect immediately, including mid-transfer. The external chain may hold a partial shift; it is not latched because rclk is forced 0.
- Capture:
  - At any clk edge with strobe=1, led_in is captured.
  - If state=IDLE, the value loads straight into the shift register and the transfer starts at that edge.
  - Otherwise it is written to the pending register and the pending flag is set. A later strobe overwrites pending (latest wins).
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: busy=0, srclk=0, rclk=0.
    - On strobe: load led_in (strobe has priority over pending and clears it).
    - Else if pending set: load pending and clear the flag.
    - On load: divider=0, bit counter=0, go to SHIFT_LO.
  - SHIFT_LO: srclk=0; ser = current bit (bit 7-n if MSB_FIRST, else bit n). Hold for CLK_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: srclk=1; ser held stable. Hold for CLK_DIV cycles.
    - If bit counter=7, go to LATCH.
    - Else increment the counter and go to SHIFT_LO.
  - LATCH: srclk=0, rclk=1, ser=0. Hold for CLK_DIV cycles, then go to IDLE. shown takes the transferred byte on the exit edge.
- Timing:
  - busy is high for exactly 17*CLK_DIV clk cycles per transfer.
  - ser changes only on SHIFT_LO entry, so it is stable ≥CLK_DIV cycles before each srclk rise and until the next SHIFT_LO.
- Back-to-back:
  - If pending was set during a transfer, IDLE lasts exactly one cycle (busy=0) before the next transfer starts.
  - A strobe on the LATCH exit edge goes to pending.
  - A strobe during that one IDLE cycle starts the transfer with that value and discards the older pending value.
- Equal values are not suppressed: every strobe produces a full transfer.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-transfer: CLK_DIV=2; strobe 8'hFF, assert rst_n=0 at cycle 10 → ser/srclk/rclk/busy=0 the same cycle; shown=8'h00; no rclk pulse afterwards.
- Single byte: CLK_DIV=2, MSB_FIRST=1; strobe led_in=8'hA5 at edge 0 → ser sampled at the 8 srclk rises = 1,0,1,0,0,1,0,1; rclk high for 2 cycles; busy high 34 cycles; shown=8'hA5 after.
- LSB-first: MSB_FIRST=0, CLK_DIV=1; strobe 8'h01 → ser=1 at the first srclk rise and 0 at the remaining 7; busy high 17 cycles.
- Latest-wins buffering: CLK_DIV=2; strobe 8'h11, then 8'h22 at cycle 5 and 8'h33 at cycle 9 → transfers 8'h11 then 8'h33 only, with exactly one busy=0 cycle between them; shown ends at 8'h33.
- Strobe on IDLE gap: with pending=8'h44, strobe 8'h55 during the one-cycle IDLE gap → next transfer is 8'h55; 8'h44 is never shifted.
- Repeat value: two strobes of 8'h0F spaced 40 cycles apart at CLK_DIV=2 → two complete 34-cycle transfers, each with exactly 8 srclk and 1 rclk pulse.
